// File: rtl/traffic_conflict_monitor.sv
// Independent lamp-output safety monitor for one intersection (NS/EW red/yellow/green).
// Detects conflicting or illegal lamp states, bad sequences and short timing, then
// latches a fault code and requests cabinet flash.
// Optional: define TLM_WATCHDOG_EN to compile in the stuck-phase watchdog (code 7).
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW  = 5,
  parameter int unsigned MIN_ALL_RED = 2,
  parameter int unsigned MAX_STABLE  = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_red,
  input  logic       ns_yellow,
  input  logic       ns_green,
  input  logic       ew_red,
  input  logic       ew_yellow,
  input  logic       ew_green,
  input  logic       clear_fault,
  output logic       armed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req
);

  localparam int unsigned VEC_W  = 6;
  localparam int unsigned LAMP_W = 3;

  localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

  localparam logic [2:0] CODE_NONE          = 3'd0;
  localparam logic [2:0] CODE_CONFLICT      = 3'd1;
  localparam logic [2:0] CODE_MULTI_LAMP    = 3'd2;
  localparam logic [2:0] CODE_NO_LAMP       = 3'd3;
  localparam logic [2:0] CODE_SHORT_YELLOW  = 3'd4;
  localparam logic [2:0] CODE_SHORT_ALL_RED = 3'd5;
  localparam logic [2:0] CODE_BAD_SEQ       = 3'd6;
  localparam logic [2:0] CODE_WATCHDOG      = 3'd7;

  // Elaboration guard: thresholds must fit in the counters.
  if ((64'(MIN_YELLOW) >= (64'(1) << CNT_W)) ||
      (64'(MIN_ALL_RED) >= (64'(1) << CNT_W)) ||
      (64'(MAX_STABLE) >= (64'(1) << CNT_W))) begin : g_param_check
    $error("traffic_conflict_monitor: thresholds must be below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    ST_ARMING  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] code_d;

  logic [VEC_W-1:0]  cur_vec, prev_vec;
  logic [LAMP_W-1:0] ns_cur, ew_cur, ns_prev, ew_prev;

  logic [CNT_W-1:0] ns_yel_cnt, ew_yel_cnt, all_red_cnt;
  logic             first_green_exempt;

  logic conflict, multi_lamp, no_lamp, short_yellow, short_all_red, bad_seq, wd_viol;
  logic ns_y2r, ew_y2r, ns_r2g, ew_r2g, all_red, lamps_legal;
  logic [2:0] viol_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic bad_step(input logic [LAMP_W-1:0] p, input logic [LAMP_W-1:0] c);
    return ((p == LAMP_G) && (c == LAMP_R)) ||
           ((p == LAMP_R) && (c == LAMP_Y)) ||
           ((p == LAMP_Y) && (c == LAMP_G));
  endfunction

  assign ns_cur  = cur_vec[5:3];
  assign ew_cur  = cur_vec[2:0];
  assign ns_prev = prev_vec[5:3];
  assign ew_prev = prev_vec[2:0];

  // Lamp sampling: current and previous lamp vectors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_vec  <= '0;
      prev_vec <= '0;
    end else begin
      cur_vec  <= {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
      prev_vec <= cur_vec;
    end
  end

  // Yellow and all-red run counters plus first-green exemption; cleared while arming.
  always_ff @(posedge clk) begin
    if (!reset || (state_q == ST_ARMING)) begin
      ns_yel_cnt         <= '0;
      ew_yel_cnt         <= '0;
      all_red_cnt        <= '0;
      first_green_exempt <= 1'b1;
    end else begin
      ns_yel_cnt  <= ns_cur[1] ? sat_inc(ns_yel_cnt) : '0;
      ew_yel_cnt  <= ew_cur[1] ? sat_inc(ew_yel_cnt) : '0;
      all_red_cnt <= all_red ? sat_inc(all_red_cnt) : '0;
      if ((state_q == ST_MONITOR) && (ns_r2g || ew_r2g)) begin
        first_green_exempt <= 1'b0;
      end
    end
  end

`ifdef TLM_WATCHDOG_EN
  logic [CNT_W-1:0] stable_cnt, stable_inc;

  // Unchanged-vector run length including the current cycle.
  always_comb stable_inc = (cur_vec == prev_vec) ? sat_inc(stable_cnt) : '0;

  // Stable counter register; cleared while arming.
  always_ff @(posedge clk) begin
    if (!reset || (state_q == ST_ARMING)) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_inc;
    end
  end

  assign wd_viol = (stable_inc >= CNT_W'(MAX_STABLE));
`else
  assign wd_viol = 1'b0;
`endif

  // Per-cycle rule evaluation on the sampled lamp vector.
  always_comb begin
    all_red       = (ns_cur == LAMP_R) && (ew_cur == LAMP_R);
    conflict      = (ns_cur[1] | ns_cur[0]) & (ew_cur[1] | ew_cur[0]);
    multi_lamp    = !$onehot0(ns_cur) || !$onehot0(ew_cur);
    no_lamp       = (ns_cur == '0) || (ew_cur == '0);
    lamps_legal   = $onehot(ns_cur) && $onehot(ew_cur) && !conflict;
    ns_y2r        = (ns_prev == LAMP_Y) && (ns_cur == LAMP_R);
    ew_y2r        = (ew_prev == LAMP_Y) && (ew_cur == LAMP_R);
    ns_r2g        = (ns_prev == LAMP_R) && (ns_cur == LAMP_G);
    ew_r2g        = (ew_prev == LAMP_R) && (ew_cur == LAMP_G);
    short_yellow  = (ns_y2r && (ns_yel_cnt < CNT_W'(MIN_YELLOW))) ||
                    (ew_y2r && (ew_yel_cnt < CNT_W'(MIN_YELLOW)));
    short_all_red = (ns_r2g || ew_r2g) && !first_green_exempt &&
                    (all_red_cnt < CNT_W'(MIN_ALL_RED));
    bad_seq       = bad_step(ns_prev, ns_cur) || bad_step(ew_prev, ew_cur);
  end

  // Lowest-numbered violation wins.
  always_comb begin
    viol_code = CODE_NONE;
    if (conflict)           viol_code = CODE_CONFLICT;
    else if (multi_lamp)    viol_code = CODE_MULTI_LAMP;
    else if (no_lamp)       viol_code = CODE_NO_LAMP;
    else if (short_yellow)  viol_code = CODE_SHORT_YELLOW;
    else if (short_all_red) viol_code = CODE_SHORT_ALL_RED;
    else if (bad_seq)       viol_code = CODE_BAD_SEQ;
    else if (wd_viol)       viol_code = CODE_WATCHDOG;
  end

  // Next-state and fault-code selection.
  always_comb begin
    state_d = state_q;
    code_d  = fault_code;
    unique case (state_q)
      ST_ARMING: begin
        code_d = CODE_NONE;
        if (lamps_legal) state_d = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (viol_code != CODE_NONE) begin
          state_d = ST_FAULT;
          code_d  = viol_code;
        end
      end
      ST_FAULT: begin
        if (clear_fault && all_red) begin
          state_d = ST_ARMING;
          code_d  = CODE_NONE;
        end
      end
      default: begin
        state_d = ST_ARMING;
        code_d  = CODE_NONE;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_ARMING;
      armed      <= 1'b0;
      fault      <= 1'b0;
      flash_req  <= 1'b0;
      fault_code <= CODE_NONE;
    end else begin
      state_q    <= state_d;
      armed      <= (state_d == ST_MONITOR);
      fault      <= (state_d == ST_FAULT);
      flash_req  <= (state_d == ST_FAULT);
      fault_code <= code_d;
    end
  end

endmodule
